// File: rtl/reset_sequencer_if.sv
// Reset-sequencer control/status bundle: clock-lock and reset requests in,
// staged active-low resets plus cause/busy status out.
interface reset_sequencer_if;
  logic       clk_locked;
  logic       sw_rst_req;
  logic       wdt_bark;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic [2:0] rst_cause;
  logic       busy;

  // master: the SoC side that raises requests and consumes the resets
  modport master (
    output clk_locked,
    output sw_rst_req,
    output wdt_bark,
    input  periph_rst_n,
    input  core_rst_n,
    input  rst_cause,
    input  busy
  );

  // slave: the sequencer itself
  modport slave (
    input  clk_locked,
    input  sw_rst_req,
    input  wdt_bark,
    output periph_rst_n,
    output core_rst_n,
    output rst_cause,
    output busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: peripherals/fabric first, CPU core STAGGER_CYCLES later.
// Re-sequences on software request, watchdog bark or loss of clock lock.
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.slave  seq
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [2:0] CAUSE_EXT = 3'b001;
  localparam logic [2:0] CAUSE_SW  = 3'b010;
  localparam logic [2:0] CAUSE_WDT = 3'b100;

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_HOLD       = 2'd1,
    ST_REL_PERIPH = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       cause_reg, cause_next;
  logic             periph_rst_n_reg;
  logic             core_rst_n_reg;
  logic             busy_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_ASSERT: begin
        count_next = '0;
        if (seq.clk_locked) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!seq.clk_locked) begin
          state_next = ST_ASSERT;
          count_next = '0;
        end else if (count_reg == HOLD_LAST) begin
          state_next = ST_REL_PERIPH;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      ST_REL_PERIPH: begin
        if (!seq.clk_locked) begin
          state_next = ST_ASSERT;
          count_next = '0;
        end else if (count_reg == STAGGER_LAST) begin
          state_next = ST_RUN;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      ST_RUN: begin
        count_next = '0;
        // Lock loss takes precedence and is not a recorded cause
        if (!seq.clk_locked) begin
          state_next = ST_ASSERT;
        end else if (seq.wdt_bark) begin
          state_next = ST_ASSERT;
          cause_next = CAUSE_WDT;
        end else if (seq.sw_rst_req) begin
          state_next = ST_ASSERT;
          cause_next = CAUSE_SW;
        end
      end
      default: begin
        state_next = ST_ASSERT;
        count_next = '0;
      end
    endcase
  end

  // Reset outputs are decoded from the next state so they toggle on the same
  // edge as the state that owns them, while remaining plain flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_ASSERT;
      count_reg        <= '0;
      cause_reg        <= CAUSE_EXT;
      periph_rst_n_reg <= 1'b0;
      core_rst_n_reg   <= 1'b0;
      busy_reg         <= 1'b1;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      cause_reg        <= cause_next;
      periph_rst_n_reg <= (state_next == ST_REL_PERIPH) || (state_next == ST_RUN);
      core_rst_n_reg   <= (state_next == ST_RUN);
      busy_reg         <= (state_next != ST_RUN);
    end
  end

  assign seq.periph_rst_n = periph_rst_n_reg;
  assign seq.core_rst_n   = core_rst_n_reg;
  assign seq.rst_cause    = cause_reg;
  assign seq.busy         = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: the same test list is run against a 16/8 instance and a 1/1 instance.
module tb_reset_sequencer;

  logic clk;
  logic rst_v    [2];
  logic locked_v [2];
  logic sw_v     [2];
  logic wdt_v    [2];
  logic       periph_o [2];
  logic       core_o   [2];
  logic       busy_o   [2];
  logic [2:0] cause_o  [2];

  int errors = 0;
  int checks = 0;

  reset_sequencer_if bus0 ();
  reset_sequencer_if bus1 ();

  assign bus0.clk_locked = locked_v[0];
  assign bus0.sw_rst_req = sw_v[0];
  assign bus0.wdt_bark   = wdt_v[0];
  assign bus1.clk_locked = locked_v[1];
  assign bus1.sw_rst_req = sw_v[1];
  assign bus1.wdt_bark   = wdt_v[1];

  assign periph_o[0] = bus0.periph_rst_n;
  assign core_o[0]   = bus0.core_rst_n;
  assign busy_o[0]   = bus0.busy;
  assign cause_o[0]  = bus0.rst_cause;
  assign periph_o[1] = bus1.periph_rst_n;
  assign core_o[1]   = bus1.core_rst_n;
  assign busy_o[1]   = bus1.busy;
  assign cause_o[1]  = bus1.rst_cause;

  reset_sequencer #(.HOLD_CYCLES(16), .STAGGER_CYCLES(8)) dut0 (
    .clk (clk),
    .rst (rst_v[0]),
    .seq (bus0.slave)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst_v[1]),
    .seq (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic int stag_of(int d);
    return (d == 0) ? 8 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {periph_rst_n, core_rst_n, busy}
  function automatic logic [2:0] pcb(int d);
    return {periph_o[d], core_o[d], busy_o[d]};
  endfunction

  // Inputs must already allow HOLD entry on the next edge (edge E).
  // pulse_at >= 0 raises sw_rst_req for one cycle after the check at E+pulse_at.
  task automatic check_release(int d, string tag, int pulse_at);
    int h;
    int s;
    h = hold_of(d);
    s = stag_of(d);
    tick();
    chk($sformatf("%s_d%0d_E", tag, d), pcb(d), 3'b001);
    for (int k = 1; k <= h + s; k++) begin
      sw_v[d] = (k - 1 == pulse_at);
      tick();
      chk($sformatf("%s_d%0d_E+%0d", tag, d, k), pcb(d), {k >= h, k >= h + s, k < h + s});
    end
    sw_v[d] = 1'b0;
  endtask

  task automatic run_all(int d);
    // 1: power-on reset then release
    rst_v[d] = 1'b1;
    locked_v[d] = 1'b1;
    repeat (5) tick();
    chk($sformatf("t1_reset_pcb_d%0d", d), pcb(d), 3'b001);
    chk($sformatf("t1_reset_cause_d%0d", d), cause_o[d], 3'b001);
    rst_v[d] = 1'b0;
    check_release(d, "t1", -1);
    chk($sformatf("t1_cause_d%0d", d), cause_o[d], 3'b001);

    // 2: reset released while the clock is not locked
    rst_v[d] = 1'b1;
    tick();
    rst_v[d] = 1'b0;
    locked_v[d] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 10 == 9) chk($sformatf("t2_unlocked_%0d_d%0d", i, d), pcb(d), 3'b001);
    end
    locked_v[d] = 1'b1;
    check_release(d, "t2", -1);
    chk($sformatf("t2_cause_d%0d", d), cause_o[d], 3'b001);

    // 3: software reset request in RUN
    sw_v[d] = 1'b1;
    tick();
    sw_v[d] = 1'b0;
    chk($sformatf("t3_sw_pcb_d%0d", d), pcb(d), 3'b001);
    chk($sformatf("t3_sw_cause_d%0d", d), cause_o[d], 3'b010);
    check_release(d, "t3", -1);
    chk($sformatf("t3_cause_kept_d%0d", d), cause_o[d], 3'b010);

    // 4: simultaneous sw and wdt, watchdog wins
    sw_v[d] = 1'b1;
    wdt_v[d] = 1'b1;
    tick();
    sw_v[d] = 1'b0;
    wdt_v[d] = 1'b0;
    chk($sformatf("t4_both_pcb_d%0d", d), pcb(d), 3'b001);
    chk($sformatf("t4_both_cause_d%0d", d), cause_o[d], 3'b100);
    check_release(d, "t4", -1);

    // 5: request during HOLD is ignored (re-enter via lock loss so cause stays 100)
    locked_v[d] = 1'b0;
    tick();
    chk($sformatf("t5_lockloss_pcb_d%0d", d), pcb(d), 3'b001);
    locked_v[d] = 1'b1;
    check_release(d, "t5", (hold_of(d) > 5) ? 5 : 0);
    chk($sformatf("t5_cause_d%0d", d), cause_o[d], 3'b100);
    tick();
    chk($sformatf("t5_still_run_d%0d", d), pcb(d), 3'b110);

    // 6a: rst during REL_PERIPH
    locked_v[d] = 1'b0;
    tick();
    locked_v[d] = 1'b1;
    tick();
    repeat (hold_of(d)) tick();
    chk($sformatf("t6_in_rel_d%0d", d), pcb(d), 3'b101);
    rst_v[d] = 1'b1;
    tick();
    rst_v[d] = 1'b0;
    chk($sformatf("t6_rst_pcb_d%0d", d), pcb(d), 3'b001);
    chk($sformatf("t6_rst_cause_d%0d", d), cause_o[d], 3'b001);
    check_release(d, "t6a", -1);

    // 6b: wdt alone, then lock loss in RUN keeps the cause
    wdt_v[d] = 1'b1;
    tick();
    wdt_v[d] = 1'b0;
    chk($sformatf("t6_wdt_cause_d%0d", d), cause_o[d], 3'b100);
    check_release(d, "t6b", -1);
    locked_v[d] = 1'b0;
    tick();
    chk($sformatf("t6_lockloss_pcb_d%0d", d), pcb(d), 3'b001);
    chk($sformatf("t6_lockloss_cause_d%0d", d), cause_o[d], 3'b100);
    locked_v[d] = 1'b1;
    check_release(d, "t6c", -1);
    chk($sformatf("t6_final_cause_d%0d", d), cause_o[d], 3'b100);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i]    = 1'b1;
      locked_v[i] = 1'b1;
      sw_v[i]     = 1'b0;
      wdt_v[i]    = 1'b0;
    end
    tick();
    run_all(0);
    rst_v[0] = 1'b1;
    run_all(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
